// File: rtl/maze_carver_dfs.sv
// ---------------------------------------------------------------------------
// maze_carver_dfs
//   Generates a perfect maze on a CELLS_X x CELLS_Y grid with an iterative
//   depth-first backtracker. It uses an on-chip stack of cell coordinates and
//   a 16-bit Galois LFSR (mask 0xB400) for direction choice. Per-cell wall bits
//   are exposed to the renderer through an asynchronous read port.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        generation request (accepted only when idle/done, not busy)
//   seed[15:0]   LFSR seed, captured on accepted start (0 selects 0xACE1)
//   rd_x, rd_y   read coordinates
//   rd_walls     {south, east} walls of (rd_x, rd_y), combinational
//   busy         high while generating
//   done         high from completion until the next accepted start or reset
//   visited_cnt  (only with MAZE_CARVER_PROGRESS_EN) number of cells visited
//
// Optional feature macro: MAZE_CARVER_PROGRESS_EN adds the visited_cnt port.
//
// FSM states
//   state | meaning
//   IDLE  | waiting for start after reset
//   CLEAR | one cell per cycle: walls=11, visited=0
//   SEED  | visit and push (0,0)
//   PICK  | choose a random unvisited neighbour, step LFSR
//   CARVE | remove shared wall, visit and push neighbour
//   POP   | backtrack one stack entry
//   DONE  | maze held until next start
// ---------------------------------------------------------------------------
module maze_carver_dfs #(
    parameter int CELLS_X = 16,
    parameter int CELLS_Y = 8,
    parameter int XW      = $clog2(CELLS_X),
    parameter int YW      = $clog2(CELLS_Y)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   seed,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic [1:0]    rd_walls,
    output logic          busy,
    output logic          done
`ifdef MAZE_CARVER_PROGRESS_EN
    ,
    output logic [$clog2(CELLS_X*CELLS_Y+1)-1:0] visited_cnt
`endif
);

    localparam int N   = CELLS_X * CELLS_Y;
    localparam int AW  = $clog2(N);
    localparam int SPW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, SEED, PICK, CARVE, POP, DONE
    } state_t;

    state_t state, state_nx;

    logic             wall_e  [N];
    logic             wall_s  [N];
    logic             visited [N];
    logic [XW+YW-1:0] stack   [N];

    logic [SPW-1:0] sp;
    logic [AW-1:0]  clr_idx;
    logic [15:0]    lfsr;
    logic [XW-1:0]  cur_x;
    logic [YW-1:0]  cur_y;
    logic [1:0]     dir_q;

    logic           accept;
    int             cur_lin;
    logic [AW-1:0]  cur_addr, a_e, a_s, a_w, a_n, nb_addr;
    logic [3:0]     mask;
    logic [1:0]     pick_dir;
    logic [XW-1:0]  nb_x;
    logic [YW-1:0]  nb_y;

    // Start is ignored while busy; DONE still has busy high for its first
    // cycle, which keeps the completion latency at exactly 5N clocks.
    assign accept = start && !busy && (state == IDLE || state == DONE);

    assign cur_lin  = int'(cur_y) * CELLS_X + int'(cur_x);
    assign cur_addr = AW'(cur_lin);
    assign a_e      = AW'(cur_lin + 1);
    assign a_s      = AW'(cur_lin + CELLS_X);
    assign a_w      = AW'(cur_lin - 1);
    assign a_n      = AW'(cur_lin - CELLS_X);

    // Neighbour mask: bit0=E, bit1=S, bit2=W, bit3=N (in bounds and unvisited)
    always_comb begin
        mask    = 4'b0000;
        mask[0] = (int'(cur_x) < CELLS_X - 1) && !visited[a_e];
        mask[1] = (int'(cur_y) < CELLS_Y - 1) && !visited[a_s];
        mask[2] = (int'(cur_x) > 0)           && !visited[a_w];
        mask[3] = (int'(cur_y) > 0)           && !visited[a_n];
    end

    // First set mask bit scanning from lfsr[1:0] upward, modulo 4
    always_comb begin
        logic found;
        pick_dir = 2'd0;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && mask[lfsr[1:0] + 2'(k)]) begin
                pick_dir = lfsr[1:0] + 2'(k);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        nb_x    = cur_x;
        nb_y    = cur_y;
        nb_addr = a_e;
        case (dir_q)
            2'd0: begin nb_x = cur_x + XW'(1); nb_addr = a_e; end
            2'd1: begin nb_y = cur_y + YW'(1); nb_addr = a_s; end
            2'd2: begin nb_x = cur_x - XW'(1); nb_addr = a_w; end
            default: begin nb_y = cur_y - YW'(1); nb_addr = a_n; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CLEAR;
            CLEAR:   if (clr_idx == AW'(N - 1)) state_nx = SEED;
            SEED:    state_nx = PICK;
            PICK:    state_nx = (mask != 4'b0000) ? CARVE : POP;
            CARVE:   state_nx = PICK;
            POP:     state_nx = (sp == SPW'(1)) ? DONE : PICK;
            DONE:    if (accept) state_nx = CLEAR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                wall_e[i]  <= 1'b1;
                wall_s[i]  <= 1'b1;
                visited[i] <= 1'b0;
            end
            sp      <= '0;
            clr_idx <= '0;
            lfsr    <= 16'hACE1;
            cur_x   <= '0;
            cur_y   <= '0;
            dir_q   <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MAZE_CARVER_PROGRESS_EN
            visited_cnt <= '0;
`endif
        end else begin
            if (accept) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                clr_idx <= '0;
                lfsr    <= (seed == 16'h0000) ? 16'hACE1 : seed;
`ifdef MAZE_CARVER_PROGRESS_EN
                visited_cnt <= '0;
`endif
            end
            case (state)
                CLEAR: begin
                    wall_e[clr_idx]  <= 1'b1;
                    wall_s[clr_idx]  <= 1'b1;
                    visited[clr_idx] <= 1'b0;
                    clr_idx <= (clr_idx == AW'(N - 1)) ? '0 : clr_idx + AW'(1);
                end
                SEED: begin
                    visited[0] <= 1'b1;
                    sp         <= SPW'(1);
                    cur_x      <= '0;
                    cur_y      <= '0;
`ifdef MAZE_CARVER_PROGRESS_EN
                    visited_cnt <= visited_cnt + 1'b1;
`endif
                end
                PICK: begin
                    lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
                    dir_q <= pick_dir;
                end
                CARVE: begin
                    case (dir_q)
                        2'd0:    wall_e[cur_addr] <= 1'b0;
                        2'd1:    wall_s[cur_addr] <= 1'b0;
                        2'd2:    wall_e[a_w]      <= 1'b0;
                        default: wall_s[a_n]      <= 1'b0;
                    endcase
                    visited[nb_addr] <= 1'b1;
                    sp    <= sp + SPW'(1);
                    cur_x <= nb_x;
                    cur_y <= nb_y;
`ifdef MAZE_CARVER_PROGRESS_EN
                    visited_cnt <= visited_cnt + 1'b1;
`endif
                end
                POP: begin
                    sp <= sp - SPW'(1);
                    if (sp != SPW'(1))
                        {cur_x, cur_y} <= stack[AW'(sp - SPW'(2))];
                end
                DONE: begin
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stack contents need no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (state == SEED)
            stack[0] <= '0;
        else if (state == CARVE)
            stack[AW'(sp)] <= {nb_x, nb_y};
    end

    logic          rd_in;
    logic [AW-1:0] rd_addr;
    assign rd_in    = (int'(rd_x) < CELLS_X) && (int'(rd_y) < CELLS_Y);
    assign rd_addr  = AW'(int'(rd_y) * CELLS_X + int'(rd_x));
    assign rd_walls = rd_in ? {wall_s[rd_addr], wall_e[rd_addr]} : 2'b11;

endmodule
